// File: rtl/rotary_value_ctrl.sv
// rotary_value_ctrl
//   Bounded up/down value driven by detent pulses from the rotary-encoder
//   direction decoder. Repeated quick turns in one direction switch from
//   step 1 to step STEP_FAST. The centre push-button returns the value to INIT.
//
// Ports
//   CLK           system clock, rising edge
//   RESET_N       asynchronous active-low reset
//   rotary_event  one-cycle detent pulse
//   rotary_right  direction, valid with rotary_event (1 = increment)
//   ROT_CENTER    raw asynchronous push-button level
//   value         registered current value
//   value_changed one-cycle pulse when value takes a new, different value
//   at_min        value == MIN
//   at_max        value == MAX
//
// Build option
//   ROTARY_VALUE_WRAP_EN : modulo arithmetic over MIN..MAX instead of saturation;
//                          value_changed then pulses on every accepted event.

module rotary_value_ctrl #(
  parameter int WIDTH       = 8,
  parameter int MIN         = 0,
  parameter int MAX         = 99,
  parameter int INIT        = 0,
  parameter int STEP_FAST   = 4,
  parameter int FAST_WINDOW = 5000000
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             rotary_event,
  input  logic             rotary_right,
  input  logic             ROT_CENTER,
  output logic [WIDTH-1:0] value,
  output logic             value_changed,
  output logic             at_min,
  output logic             at_max
);

  localparam int unsigned GAP_W = (FAST_WINDOW < 2) ? 1 : $clog2(FAST_WINDOW + 1);
  localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(FAST_WINDOW);

  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);

  // One extra bit keeps value+step and MIN+step free of overflow.
  localparam logic [WIDTH:0] MIN_X  = (WIDTH+1)'(MIN);
  localparam logic [WIDTH:0] MAX_X  = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP_FAST);
  localparam logic [WIDTH:0] ONE_X  = (WIDTH+1)'(1);

`ifdef ROTARY_VALUE_WRAP_EN
  localparam logic [WIDTH:0] RANGE_X = (WIDTH+1)'(MAX - MIN + 1);
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic {
    SLOW,
    FAST
  } state_t;

  state_t           state;
  logic [1:0]       streak;
  logic             last_dir;
  logic [GAP_W-1:0] gap;

  logic ctr_s1, ctr_s2, ctr_s3;
  logic ctr_q;
  logic ev_q;
  logic dir_q;

  logic             center_edge;
  logic             accept;
  logic             quick;
  logic [WIDTH:0]   step;
  logic [WIDTH:0]   cur_x;
  logic [WIDTH:0]   calc_x;
  logic [WIDTH-1:0] next_value;

  always_comb begin
    center_edge = ctr_s2 & ~ctr_s3;
    // A centre edge registered alongside an event suppresses that event.
    accept      = ev_q & ~ctr_q;
    quick       = (gap < GAP_SAT) && (dir_q == last_dir);
    step        = (state == FAST && quick) ? STEP_X : ONE_X;
    cur_x       = {1'b0, value};
    calc_x      = cur_x;
    if (dir_q) begin
      calc_x = cur_x + step;
      if (calc_x > MAX_X) begin
`ifdef ROTARY_VALUE_WRAP_EN
        calc_x = calc_x - RANGE_X;
`else
        calc_x = MAX_X;
`endif
      end
    end else begin
      if (cur_x < MIN_X + step) begin
`ifdef ROTARY_VALUE_WRAP_EN
        calc_x = cur_x + RANGE_X - step;
`else
        calc_x = MIN_X;
`endif
      end else begin
        calc_x = cur_x - step;
      end
    end
    next_value = calc_x[WIDTH-1:0];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      value         <= INIT_V;
      value_changed <= 1'b0;
      state         <= SLOW;
      streak        <= '0;
      last_dir      <= 1'b0;
      gap           <= GAP_SAT;
      ctr_s1        <= 1'b0;
      ctr_s2        <= 1'b0;
      ctr_s3        <= 1'b0;
      ctr_q         <= 1'b0;
      ev_q          <= 1'b0;
      dir_q         <= 1'b0;
    end else begin
      ctr_s1 <= ROT_CENTER;
      ctr_s2 <= ctr_s1;
      ctr_s3 <= ctr_s2;
      // Input stage: the update lands one edge after the event is sampled.
      ctr_q  <= center_edge;
      ev_q   <= rotary_event;
      if (rotary_event) begin
        dir_q <= rotary_right;
      end

      if (ctr_q) begin
        value         <= INIT_V;
        value_changed <= (value != INIT_V);
        state         <= SLOW;
        streak        <= '0;
        gap           <= GAP_SAT;
      end else if (accept) begin
        value         <= next_value;
        value_changed <= WRAP_EN ? 1'b1 : (next_value != value);
        last_dir      <= dir_q;
        gap           <= '0;
        if (quick) begin
          if (state == SLOW) begin
            streak <= (streak == 2'd3) ? 2'd3 : streak + 2'd1;
            if (streak >= 2'd2) begin
              state <= FAST;
            end
          end
        end else begin
          // Reversal, or same direction after the window closed.
          state  <= SLOW;
          streak <= 2'd1;
        end
      end else begin
        value_changed <= 1'b0;
        if (gap != GAP_SAT) begin
          gap <= gap + GAP_W'(1);
        end
        if (state == FAST && gap == GAP_SAT) begin
          state  <= SLOW;
          streak <= '0;
        end
      end
    end
  end

  assign at_min = (value == MIN_V);
  assign at_max = (value == MAX_V);

endmodule

// File: tb/tb_rotary_value_ctrl.sv
module tb_rotary_value_ctrl;

  localparam int WIDTH     = 8;
  localparam int MIN       = 0;
  localparam int MAX       = 99;
  localparam int INIT      = 0;
  localparam int STEP_FAST = 4;
  localparam int FW        = 100;

  logic       CLK          = 1'b0;
  logic       RESET_N      = 1'b0;
  logic       rotary_event = 1'b0;
  logic       rotary_right = 1'b0;
  logic       ROT_CENTER   = 1'b0;
  logic [7:0] value;
  logic       value_changed;
  logic       at_min;
  logic       at_max;

  int unsigned cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int unsigned due;
    logic [7:0]  val;
    logic        vc;
  } exp_t;

  exp_t sb[$];

  rotary_value_ctrl #(
    .WIDTH      (WIDTH),
    .MIN        (MIN),
    .MAX        (MAX),
    .INIT       (INIT),
    .STEP_FAST  (STEP_FAST),
    .FAST_WINDOW(FW)
  ) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .rotary_event (rotary_event),
    .rotary_right (rotary_right),
    .ROT_CENTER   (ROT_CENTER),
    .value        (value),
    .value_changed(value_changed),
    .at_min       (at_min),
    .at_max       (at_max)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // One detent pulse; the expected result is due two edges later.
  task automatic rot(input logic dir, input logic [7:0] ev, input logic ec);
    exp_t e;
    @(negedge CLK);
    rotary_event = 1'b1;
    rotary_right = dir;
    e.due = cyc + 2;
    e.val = ev;
    e.vc  = ec;
    sb.push_back(e);
    @(negedge CLK);
    rotary_event = 1'b0;
    rotary_right = 1'($urandom_range(0, 1));
  endtask

  // Scoreboard: every negedge, value/flags must match the last expected value.
  task automatic monitor();
    exp_t e;
    logic [7:0] mv;
    logic evc;
    mv = 8'(INIT);
    forever begin
      @(negedge CLK);
      evc = 1'b0;
      if (!RESET_N) begin
        mv = 8'(INIT);
      end else begin
        if (sb.size() > 0 && sb[0].due < cyc) begin
          checks++;
          errors++;
          $display("FAIL sb_missed: expectation due at cycle %0d unserved at cycle %0d", sb[0].due, cyc);
          void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
          e   = sb.pop_front();
          mv  = e.val;
          evc = e.vc;
        end
      end
      checks++;
      if (value !== mv) begin
        errors++;
        $display("FAIL value @%0d: got %0d expected %0d", cyc, value, mv);
      end
      checks++;
      if (value_changed !== evc) begin
        errors++;
        $display("FAIL value_changed @%0d: got %b expected %b", cyc, value_changed, evc);
      end
      checks++;
      if (at_min !== (mv == 8'(MIN))) begin
        errors++;
        $display("FAIL at_min @%0d: got %b expected %b", cyc, at_min, (mv == 8'(MIN)));
      end
      checks++;
      if (at_max !== (mv == 8'(MAX))) begin
        errors++;
        $display("FAIL at_max @%0d: got %b expected %b", cyc, at_max, (mv == 8'(MAX)));
      end
    end
  endtask

  task automatic test_reset();
    idle(3);
    RESET_N = 1'b1;
    #1;
    checks++;
    if (value !== 8'(INIT)) begin
      errors++;
      $display("FAIL reset_value: got %0d expected %0d", value, INIT);
    end
    checks++;
    if (value_changed !== 1'b0 || at_min !== 1'b1 || at_max !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got vc=%b min=%b max=%b expected 0 1 0", value_changed, at_min, at_max);
    end
  endtask

  // Slow right turns, then slow steps up to 10.
  task automatic test_slow();
    rot(1'b1, 8'd1, 1'b1);
    idle(198);
    rot(1'b1, 8'd2, 1'b1);
    idle(198);
    rot(1'b1, 8'd3, 1'b1);
    for (int v = 4; v <= 10; v++) begin
      idle(148);
      rot(1'b1, 8'(v), 1'b1);
    end
  endtask

  task automatic test_fast();
    logic [7:0] exp_vals [6];
    exp_vals = '{8'd11, 8'd12, 8'd13, 8'd17, 8'd21, 8'd25};
    idle(148);
    for (int i = 0; i < 6; i++) begin
      rot(1'b1, exp_vals[i], 1'b1);
      idle(8);
    end
  endtask

  task automatic test_reversal();
    rot(1'b0, 8'd24, 1'b1);
    idle(148);
    rot(1'b0, 8'd23, 1'b1);
    idle(8);
    rot(1'b0, 8'd22, 1'b1);
  endtask

  task automatic test_center();
    exp_t e;
    logic [7:0] seq [9];
    seq = '{8'd23, 8'd24, 8'd25, 8'd29, 8'd33, 8'd34, 8'd35, 8'd36, 8'd37};
    idle(148);
    for (int i = 0; i < 9; i++) begin
      rot(1'b1, seq[i], 1'b1);
      if (i == 4 || i == 7) idle(148);
      else idle(8);
    end
    // Synchronised edge coincides with the cycle rotary_event is high.
    @(negedge CLK);
    ROT_CENTER = 1'b1;
    e.due = cyc + 4;
    e.val = 8'(INIT);
    e.vc  = 1'b1;
    sb.push_back(e);
    @(negedge CLK);
    @(negedge CLK);
    rotary_event = 1'b1;
    rotary_right = 1'b1;
    @(negedge CLK);
    rotary_event = 1'b0;
    idle(10);
    ROT_CENTER = 1'b0;
    checks++;
    if (value !== 8'(INIT)) begin
      errors++;
      $display("FAIL center_value: got %0d expected %0d", value, INIT);
    end
  endtask

  task automatic test_bound_min();
    idle(20);
`ifdef ROTARY_VALUE_WRAP_EN
    rot(1'b0, 8'd99, 1'b1);
    #1;
    checks++;
    if (at_min !== 1'b0 || at_max !== 1'b1) begin
      errors++;
      $display("FAIL wrap_low_flags: got min=%b max=%b expected 0 1", at_min, at_max);
    end
    idle(8);
    rot(1'b1, 8'd0, 1'b1);
`else
    rot(1'b0, 8'd0, 1'b0);
    @(negedge CLK);
    #1;
    checks++;
    if (at_min !== 1'b1 || value_changed !== 1'b0) begin
      errors++;
      $display("FAIL sat_low_flags: got min=%b vc=%b expected 1 0", at_min, value_changed);
    end
    idle(7);
    rot(1'b0, 8'd0, 1'b0);
`endif
  endtask

  task automatic test_reset_mid_fast();
    idle(148);
    rot(1'b1, 8'd1, 1'b1);
    idle(148);
    rot(1'b1, 8'd2, 1'b1);
    idle(8);
    rot(1'b1, 8'd3, 1'b1);
    idle(8);
    rot(1'b1, 8'd4, 1'b1);
    for (int v = 8; v <= 60; v += 4) begin
      idle(8);
      rot(1'b1, 8'(v), 1'b1);
    end
    idle(8);
    // This event is already registered when reset hits; it must not apply.
    @(negedge CLK);
    rotary_event = 1'b1;
    rotary_right = 1'b1;
    @(negedge CLK);
    rotary_event = 1'b0;
    #2;
    RESET_N = 1'b0;
    #1;
    checks++;
    if (value !== 8'(INIT)) begin
      errors++;
      $display("FAIL async_reset_value: got %0d expected %0d", value, INIT);
    end
    checks++;
    if (value_changed !== 1'b0 || at_min !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_flags: got vc=%b min=%b expected 0 1", value_changed, at_min);
    end
    idle(3);
    RESET_N = 1'b1;
    idle(4);
    rot(1'b1, 8'd1, 1'b1);
    idle(8);
    rot(1'b1, 8'd2, 1'b1);
  endtask

  task automatic test_bound_max();
    idle(8);
    rot(1'b1, 8'd3, 1'b1);
    for (int v = 7; v <= 99; v += 4) begin
      idle(8);
      rot(1'b1, 8'(v), 1'b1);
    end
    idle(8);
`ifdef ROTARY_VALUE_WRAP_EN
    rot(1'b1, 8'd3, 1'b1);
`else
    rot(1'b1, 8'd99, 1'b0);
    @(negedge CLK);
    #1;
    checks++;
    if (at_max !== 1'b1 || value !== 8'd99) begin
      errors++;
      $display("FAIL sat_high: got value=%0d max=%b expected 99 1", value, at_max);
    end
`endif
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_slow();
    test_fast();
    test_reversal();
    test_center();
    test_bound_min();
    test_reset_mid_fast();
    test_bound_max();
    idle(5);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
